// File: rtl/fetch_pc_unit_pkg.sv
// Shared constants for the fetch PC unit: default widths and redirect source indices.
package fetch_pc_unit_pkg;

  localparam int ADDR_W_DEF  = 10;
  localparam int FETCH_W_DEF = 2;

  // Redirect source indices; the lower index wins when several fire together.
  localparam int REDIR_EVEN = 0;
  localparam int REDIR_ODD  = 1;

endpackage : fetch_pc_unit_pkg

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory side of the fetch PC unit: request handshake and response tagging.
interface fetch_pc_unit_if
  import fetch_pc_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              fetch_req_valid;
  logic              fetch_req_ready;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_resp_valid;
  logic              resp_pc_valid;
  logic [ADDR_W-1:0] resp_pc;

  // Fetch unit side.
  modport master (
    output fetch_req_valid,
    output fetch_addr,
    output resp_pc_valid,
    output resp_pc,
    input  fetch_req_ready,
    input  fetch_resp_valid
  );

  // Instruction memory / consumer side.
  modport slave (
    input  fetch_req_valid,
    input  fetch_addr,
    input  resp_pc_valid,
    input  resp_pc,
    output fetch_req_ready,
    output fetch_resp_valid
  );

endinterface : fetch_pc_unit_if

// File: rtl/fetch_pc_unit_chk.sv
// Protocol checker: a response with nothing to drop and nothing in flight is illegal.
module fetch_pc_unit_chk (
  input logic clk,
  input logic rst,
  input logic fetch_resp_valid,
  input logic drop_zero,
  input logic fifo_empty
);

  // Flag stray responses outside reset; the datapath itself ignores them.
  always @(posedge clk) begin
    if (rst) begin
      assert (!(fetch_resp_valid && drop_zero && fifo_empty))
        else $error("fetch_pc_unit: response with no fetch outstanding");
    end
  end

endmodule : fetch_pc_unit_chk

// File: rtl/fetch_pc_unit_pc_tag_fifo.sv
// PC tag FIFO: in-order record of the PCs of in-flight fetch groups.
// Clear has priority over push/pop; push when full and pop when empty are ignored.
module fetch_pc_unit_pc_tag_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  assign full      = (cnt_r == CNT_W'(DEPTH));
  assign empty     = (cnt_r == {CNT_W{1'b0}});
  assign count     = cnt_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Pointer and occupancy bookkeeping; reset and clear both empty the FIFO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

endmodule : fetch_pc_unit_pc_tag_fifo

// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: holds the fetch PC, issues fetch-group requests, tags responses
// with their PC and applies prioritised redirects (held pending across stalls).
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                FETCH_W   = FETCH_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC  = {ADDR_W{1'b0}},
  parameter int                NUM_REDIR = 2,
  parameter int                MAX_OUT   = 4,
  parameter int                CNT_W     = $clog2(MAX_OUT + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic [NUM_REDIR-1:0]        redir_valid,
  input  logic [NUM_REDIR*ADDR_W-1:0] redir_target,
  fetch_pc_unit_if.master             fif,
  output logic                        pending_redir,
  output logic [CNT_W-1:0]            outstanding
);

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_next_s;
  logic              pend_valid_r;
  logic              pend_valid_next_s;
  logic [ADDR_W-1:0] pend_target_r;
  logic [ADDR_W-1:0] pend_target_next_s;
  logic [CNT_W-1:0]  drop_r;
  logic [CNT_W-1:0]  drop_next_s;
  logic [CNT_W:0]    squash_total_s;

  logic              redir_any_s;
  logic [ADDR_W-1:0] redir_sel_s;
  logic              drop_zero_s;
  logic              handshake_s;
  logic              push_s;
  logic              pop_s;
  logic              clear_s;

  logic [ADDR_W-1:0] fifo_head_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [CNT_W-1:0]  fifo_count_s;

  assign redir_any_s = |redir_valid;
  assign drop_zero_s = (drop_r == {CNT_W{1'b0}});

  // Lowest-index asserted redirect source supplies the target.
  always_comb begin
    redir_sel_s = {ADDR_W{1'b0}};
    for (int i = NUM_REDIR - 1; i >= 0; i--) begin
      if (redir_valid[i]) begin
        redir_sel_s = redir_target[i*ADDR_W +: ADDR_W];
      end else begin
        redir_sel_s = redir_sel_s;
      end
    end
  end

  // Requests are suppressed while a redirect is arriving or still pending.
  assign fif.fetch_req_valid = rst & ~stall & ~fifo_full_s & ~redir_any_s & ~pend_valid_r;
  assign fif.fetch_addr      = pc_r;
  assign handshake_s         = fif.fetch_req_valid & fif.fetch_req_ready;

  // A response consumes the FIFO head only when nothing is owed to the drop counter
  // and no redirect is squashing this cycle.
  assign pop_s             = rst & fif.fetch_resp_valid & ~redir_any_s & drop_zero_s & ~fifo_empty_s;
  assign fif.resp_pc_valid = pop_s;
  assign fif.resp_pc       = pop_s ? fifo_head_s : {ADDR_W{1'b0}};

  assign pending_redir = pend_valid_r;
  assign outstanding   = fifo_count_s;

  // Next PC, pending redirect, drop counter and FIFO control.
  always_comb begin
    pc_next_s          = pc_r;
    pend_valid_next_s  = pend_valid_r;
    pend_target_next_s = pend_target_r;
    drop_next_s        = drop_r;
    squash_total_s     = {1'b0, drop_r} + {1'b0, fifo_count_s};
    push_s             = 1'b0;
    clear_s            = 1'b0;
    if (redir_any_s) begin
      // Everything in flight becomes owed to the drop counter; a response this
      // cycle retires one of those owed slots.
      clear_s = 1'b1;
      if (fif.fetch_resp_valid && (squash_total_s != {(CNT_W+1){1'b0}})) begin
        squash_total_s = squash_total_s - (CNT_W+1)'(1);
      end else begin
        squash_total_s = squash_total_s;
      end
      if (squash_total_s > (CNT_W+1)'(MAX_OUT)) begin
        drop_next_s = CNT_W'(MAX_OUT);
      end else begin
        drop_next_s = squash_total_s[CNT_W-1:0];
      end
      if (stall) begin
        pend_valid_next_s  = 1'b1;
        pend_target_next_s = redir_sel_s;
      end else begin
        pc_next_s         = redir_sel_s;
        pend_valid_next_s = 1'b0;
      end
    end else begin
      if (fif.fetch_resp_valid && !drop_zero_s) begin
        drop_next_s = drop_r - CNT_W'(1);
      end else begin
        drop_next_s = drop_r;
      end
      if (!stall && pend_valid_r) begin
        pc_next_s         = pend_target_r;
        pend_valid_next_s = 1'b0;
      end else if (handshake_s) begin
        push_s    = 1'b1;
        pc_next_s = pc_r + ADDR_W'(FETCH_W);
      end else begin
        pc_next_s = pc_r;
      end
    end
  end

  // Architectural state; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_r          <= RESET_PC;
      pend_valid_r  <= 1'b0;
      pend_target_r <= {ADDR_W{1'b0}};
      drop_r        <= {CNT_W{1'b0}};
    end else begin
      pc_r          <= pc_next_s;
      pend_valid_r  <= pend_valid_next_s;
      pend_target_r <= pend_target_next_s;
      drop_r        <= drop_next_s;
    end
  end

  fetch_pc_unit_pc_tag_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .wdata (pc_r),
    .pop   (pop_s),
    .clear (clear_s),
    .rdata (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  fetch_pc_unit_chk u_chk (
    .clk              (clk),
    .rst              (rst),
    .fetch_resp_valid (fif.fetch_resp_valid),
    .drop_zero        (drop_zero_s),
    .fifo_empty       (fifo_empty_s)
  );

endmodule : fetch_pc_unit

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with hand-computed expectations.
module tb_fetch_pc_unit;
  import fetch_pc_unit_pkg::*;

  localparam int AW = 10;

  logic          clk;
  logic          rst;
  logic          stall;
  logic [1:0]    redir_valid;
  logic [2*AW-1:0] redir_target;
  logic          pending_redir;
  logic [2:0]    outstanding;

  int n_cmp;
  int n_err;

  fetch_pc_unit_if #(.ADDR_W(AW)) fif ();

  fetch_pc_unit #(
    .ADDR_W    (AW),
    .FETCH_W   (2),
    .RESET_PC  (10'h000),
    .NUM_REDIR (2),
    .MAX_OUT   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redir_valid   (redir_valid),
    .redir_target  (redir_target),
    .fif           (fif),
    .pending_redir (pending_redir),
    .outstanding   (outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_redir(input logic [1:0] v, input logic [AW-1:0] t_even, input logic [AW-1:0] t_odd);
    redir_valid = v;
    redir_target[REDIR_EVEN*AW +: AW] = t_even;
    redir_target[REDIR_ODD*AW +: AW]  = t_odd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    stall = 1'b0;
    set_redir(2'b00, 10'h000, 10'h000);
    fif.fetch_req_ready  = 1'b0;
    fif.fetch_resp_valid = 1'b0;
    cyc();
    cyc();

    // Reset state.
    #1;
    chk("rst_addr", fif.fetch_addr, 10'h000);
    chk("rst_req_valid", fif.fetch_req_valid, 1'b0);
    chk("rst_outstanding", outstanding, 3'd0);
    chk("rst_pending", pending_redir, 1'b0);
    chk("rst_resp_valid", fif.resp_pc_valid, 1'b0);
    rst = 1'b1;

    // Memory not ready: PC holds, request stays up.
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_req_valid", fif.fetch_req_valid, 1'b1);
      chk("hold_addr", fif.fetch_addr, 10'h000);
      cyc();
    end

    // Four accepted fetches fill the FIFO.
    fif.fetch_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("seq_addr", fif.fetch_addr, 32'(2 * i));
      chk("seq_outstanding", outstanding, 32'(i));
      cyc();
    end
    #1;
    chk("full_req_valid", fif.fetch_req_valid, 1'b0);
    chk("full_outstanding", outstanding, 3'd4);
    chk("full_addr", fif.fetch_addr, 10'h008);
    cyc();
    #1;
    chk("full_req_valid2", fif.fetch_req_valid, 1'b0);

    // Drain: responses carry 0,2,4,6.
    fif.fetch_req_ready  = 1'b0;
    fif.fetch_resp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_resp_valid", fif.resp_pc_valid, 1'b1);
      chk("drain_resp_pc", fif.resp_pc, 32'(2 * i));
      cyc();
    end
    fif.fetch_resp_valid = 1'b0;
    #1;
    chk("drain_outstanding", outstanding, 3'd0);
    chk("drain_req_valid", fif.fetch_req_valid, 1'b1);

    // Three in flight (8,10,12), then redirect from the odd source to 0x100.
    fif.fetch_req_ready = 1'b1;
    cyc();
    cyc();
    cyc();
    set_redir(2'b10, 10'h000, 10'h100);
    #1;
    chk("redir_req_valid", fif.fetch_req_valid, 1'b0);
    cyc();
    set_redir(2'b00, 10'h000, 10'h000);
    #1;
    chk("redir_addr", fif.fetch_addr, 10'h100);
    chk("redir_outstanding", outstanding, 3'd0);
    chk("redir_req_valid2", fif.fetch_req_valid, 1'b1);
    cyc();
    fif.fetch_req_ready  = 1'b0;
    fif.fetch_resp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("squash_resp_valid", fif.resp_pc_valid, 1'b0);
      cyc();
    end
    #1;
    chk("post_squash_valid", fif.resp_pc_valid, 1'b1);
    chk("post_squash_pc", fif.resp_pc, 10'h100);
    cyc();
    fif.fetch_resp_valid = 1'b0;
    #1;
    chk("post_squash_outstanding", outstanding, 3'd0);

    // Redirect during stall is held pending, applied after stall drops.
    stall = 1'b1;
    set_redir(2'b01, 10'h040, 10'h000);
    #1;
    chk("stall_redir_req_valid", fif.fetch_req_valid, 1'b0);
    cyc();
    set_redir(2'b00, 10'h000, 10'h000);
    #1;
    chk("pending_set", pending_redir, 1'b1);
    chk("pending_pc_held", fif.fetch_addr, 10'h102);
    cyc();
    stall = 1'b0;
    #1;
    chk("pending_apply_req_valid", fif.fetch_req_valid, 1'b0);
    chk("pending_apply_flag", pending_redir, 1'b1);
    cyc();
    fif.fetch_req_ready = 1'b1;
    #1;
    chk("pending_loaded_addr", fif.fetch_addr, 10'h040);
    chk("pending_cleared", pending_redir, 1'b0);
    chk("pending_req_valid", fif.fetch_req_valid, 1'b1);
    cyc();
    #1;
    chk("resume_addr", fif.fetch_addr, 10'h042);
    cyc();

    // Push and pop in the same cycle keep occupancy.
    fif.fetch_resp_valid = 1'b1;
    #1;
    chk("pushpop_resp_pc", fif.resp_pc, 10'h040);
    cyc();
    fif.fetch_req_ready = 1'b0;
    #1;
    chk("pushpop_outstanding", outstanding, 3'd2);
    chk("pushpop_resp_pc2", fif.resp_pc, 10'h042);
    cyc();
    #1;
    chk("pushpop_resp_pc3", fif.resp_pc, 10'h044);
    cyc();
    fif.fetch_resp_valid = 1'b0;
    #1;
    chk("pushpop_drained", outstanding, 3'd0);

    // Simultaneous redirects: source 0 wins.
    set_redir(2'b11, 10'h080, 10'h020);
    cyc();
    set_redir(2'b00, 10'h000, 10'h000);
    #1;
    chk("prio_addr", fif.fetch_addr, 10'h080);

    // PC wrap at the top of the address space.
    set_redir(2'b10, 10'h000, 10'h3FE);
    cyc();
    set_redir(2'b00, 10'h000, 10'h000);
    fif.fetch_req_ready = 1'b1;
    #1;
    chk("wrap_start_addr", fif.fetch_addr, 10'h3FE);
    chk("wrap_req_valid", fif.fetch_req_valid, 1'b1);
    cyc();
    fif.fetch_req_ready  = 1'b0;
    fif.fetch_resp_valid = 1'b1;
    #1;
    chk("wrap_addr", fif.fetch_addr, 10'h000);
    chk("wrap_resp_pc", fif.resp_pc, 10'h3FE);
    cyc();
    fif.fetch_resp_valid = 1'b0;

    // Mid-stream reset with a pending redirect and two squashed fetches owed.
    fif.fetch_req_ready = 1'b1;
    cyc();
    cyc();
    fif.fetch_req_ready = 1'b0;
    stall = 1'b1;
    set_redir(2'b01, 10'h200, 10'h000);
    cyc();
    set_redir(2'b00, 10'h000, 10'h000);
    #1;
    chk("pre_rst_pending", pending_redir, 1'b1);
    chk("pre_rst_outstanding", outstanding, 3'd0);
    rst = 1'b0;
    stall = 1'b0;
    set_redir(2'b10, 10'h000, 10'h155);
    fif.fetch_resp_valid = 1'b1;
    cyc();
    set_redir(2'b00, 10'h000, 10'h000);
    #1;
    chk("mid_rst_addr", fif.fetch_addr, 10'h000);
    chk("mid_rst_outstanding", outstanding, 3'd0);
    chk("mid_rst_pending", pending_redir, 1'b0);
    chk("mid_rst_req_valid", fif.fetch_req_valid, 1'b0);
    chk("mid_rst_resp_valid", fif.resp_pc_valid, 1'b0);
    cyc();
    rst = 1'b1;
    fif.fetch_resp_valid = 1'b0;
    #1;
    chk("after_rst_req_valid", fif.fetch_req_valid, 1'b1);
    chk("after_rst_addr", fif.fetch_addr, 10'h000);
    fif.fetch_req_ready = 1'b1;
    cyc();
    fif.fetch_req_ready  = 1'b0;
    fif.fetch_resp_valid = 1'b1;
    #1;
    chk("after_rst_resp_valid", fif.resp_pc_valid, 1'b1);
    chk("after_rst_resp_pc", fif.resp_pc, 10'h000);
    cyc();
    fif.fetch_resp_valid = 1'b0;
    #1;
    chk("after_rst_outstanding", outstanding, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fetch_pc_unit

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Parametrised next-generation program counter and fetch sequencer for the instruction front end.
- Holds the fetch PC and issues fetch-group requests to instruction memory over a valid/ready handshake.
- Tracks in-flight fetches in an in-order tag FIFO and tags each returning response with its PC.
- Accepts prioritised redirects from several sources; a redirect arriving during stall is held pending, never lost, and squashes in-flight fetches.

Parameters:
- ADDR_W, 10, PC/address width in bits.
- FETCH_W, 2, PC increment per accepted fetch group.
- RESET_PC, 0, PC value loaded on reset.
- NUM_REDIR, 2, number of redirect sources; index 0 has highest priority.
- MAX_OUT, 4, maximum outstanding fetches (tag FIFO depth, ≥2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- stall  in  1  front-end stall; no new request, PC held.
- redir_valid  in  NUM_REDIR  per-source redirect strobe.
- redir_target  in  NUM_REDIR*ADDR_W  packed targets; source i occupies slice i.
- fetch_req_valid  out  1  request to instruction memory.
- fetch_req_ready  in  1  memory accepts request.
- fetch_addr  out  ADDR_W  current PC.
- fetch_resp_valid  in  1  in-order response strobe from memory.
- resp_pc_valid  out  1  response is on the live path.
- resp_pc  out  ADDR_W  PC of the returning group.
- pending_redir  out  1  a captured redirect is waiting.
- outstanding  out  clog2(MAX_OUT+1)  FIFO occupancy.

Behaviour:
- Reset, sampled at clk with rst=0:
  - PC=RESET_PC; FIFO empty; drop_cnt=0; pending cleared.
  - All outputs 0 except fetch_addr=RESET_PC.
  - Reset overrides every simultaneous input.
- redir_any = OR(redir_valid). Selected target = lowest asserted index.
- fetch_req_valid = rst & ~stall & ~fifo_full & ~redir_any & ~pending_redir. Combinational; fetch_addr=PC.
- Handshake (fetch_req_valid & fetch_req_ready):
  - Push PC into FIFO.
  - PC <= PC+FETCH_W, modulo 2^ADDR_W (wrap, no overflow flag).
- Redirect with stall=0:
  - PC <= selected target.
  - drop_cnt <= drop_cnt + occupancy − (1 if response this cycle).
  - FIFO cleared.
  - pending_redir cleared.
- Redirect with stall=1:
  - Capture target into pending register; a newer capture overwrites an older one.
  - FIFO squash and drop_cnt update as above, applied immediately.
  - PC unchanged.
- Pending applied in the first cycle with stall=0 and no new redirect: PC <= pending target, pending cleared, no request that cycle. A new redirect in that cycle wins over pending.
- Response handling:
  - fetch_resp_valid with drop_cnt>0: drop_cnt−1, resp_pc_valid=0.
  - Otherwise: pop FIFO head, resp_pc_valid=1, resp_pc=head (combinational, same cycle).
  - A response in the same cycle as a redirect is always dropped.
- fetch_resp_valid with drop_cnt=0 and FIFO empty is a protocol error: ignored, no state change. Simulation assertion fires.
- Push and pop in the same cycle are allowed; occupancy is unchanged.
- fifo_full blocks requests only; responses continue draining.
- Stall does not block responses.
- Widths: FIFO pointers clog2(MAX_OUT); drop_cnt saturates at MAX_OUT (cannot exceed by construction).

Decomposition:
- Shared package holds:
  - FETCH_W default;
  - address-width constant;
  - redirect-source index constants (REDIR_EVEN, REDIR_ODD).
- One sub-module, pc_tag_fifo: synchronous FIFO with push/pop/clear and occupancy output, parametrised by width and depth.
- Priority select, pending register and drop counter stay in the top level.

Test Plan:
- Reset then ready=1, no stall, 4 cycles → fetch_addr 0,2,4,6; responses each return resp_pc 0,2,4,6 with resp_pc_valid=1.
- ready=0 for 5 cycles → PC holds 0, fetch_req_valid=1 throughout. With MAX_OUT=4, 4 accepted fetches and no response → fetch_req_valid=0 until a response pops.
- 3 fetches in flight (0,2,4), redirect src1 target 0x100 → next fetch_addr=0x100; next 3 responses resp_pc_valid=0; 4th response resp_pc=0x100.
- stall=1 and redirect src0 target 0x40 in the same cycle → pending_redir=1, PC unchanged. stall drops → 0x40 loaded one cycle later, then requests resume at 0x40, 0x42.
- Redirect src0=0x80 and src1=0x20 together → PC=0x80. PC at 0x3FE with FETCH_W=2 accepted → PC wraps to 0x000.
- rst=0 mid-stream with pending redirect and 2 in flight → next cycle PC=RESET_PC, outstanding=0, pending_redir=0; stray responses after reset are ignored.
